arb_requester: RTL and testbench

Upstream client for the round-robin token arbiter. Accepts transfer jobs (a length each) on a valid/ready input, buffers them in a small FIFO, and for each job runs the req/ack handshake toward its per-requester controller. It holds `req` for the job's transfer window, then releases and waits for `ack` to drop before starting the next job. One instance drives each of the `reqA`/`reqB`/`reqC` lines.

---
 rtl/arb_requester_pkg.sv | 32 +++
 rtl/arb_requester_job_fifo.sv | 63 ++++++
 rtl/arb_requester.sv | 150 +++++++++++++++
 tb/tb_arb_requester.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_requester_pkg.sv
// Shared types for the token-arbiter client side: requester FSM states and the
// arbiter selection code used by top-level wiring.
package arb_requester_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQUEST = 2'd1,
      XFER    = 2'd2,
      RELEASE = 2'd3
   } requester_state;

   typedef enum logic [1:0] {
      SEL_NONE = 2'd0,
      SEL_A    = 2'd1,
      SEL_B    = 2'd2,
      SEL_C    = 2'd3
   } selection;

   // One-hot {C,B,A} view of a selection, for driving per-requester grant lines.
   function automatic logic [2:0] sel_onehot(input selection s);
      logic [2:0] oh;
      oh = 3'b000;
      case (s)
         SEL_A:   oh = 3'b001;
         SEL_B:   oh = 3'b010;
         SEL_C:   oh = 3'b100;
         default: oh = 3'b000;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/arb_requester_job_fifo.sv
// Job length FIFO: DEPTH x LEN_W storage, wrap-around pointers, occupancy count,
// flushed by synchronous reset. Head entry is visible combinationally.
module job_fifo
   import arb_requester_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int LEN_W = 4,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [LEN_W-1:0] wdata,
   input  logic             pop,
   output logic [LEN_W-1:0] head,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [LEN_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok, pop_ok;

   assign push_ok = push && (count_q != CNT_W'(DEPTH));
   assign pop_ok  = pop && (count_q != '0);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: the pointers alone define which entries are live.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= wdata;
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/arb_requester.sv
// Arbiter client: queues transfer jobs and runs req/ack per job.
// Optional grant-wait abort when ARB_REQ_TIMEOUT_EN is defined.
module arb_requester
   import arb_requester_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int LEN_W   = 4,
   parameter int TIMEOUT = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       job_valid,
   input  logic [LEN_W-1:0]           job_len,
   output logic                       job_ready,
   output logic                       req,
   input  logic                       ack,
   output logic                       done,
   output logic                       busy,
   output logic [$clog2(DEPTH+1)-1:0] count
`ifdef ARB_REQ_TIMEOUT_EN
   ,
   output logic                       timeout
`endif
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   requester_state   state_q;
   logic             req_q, done_q, busy_q;
   logic [LEN_W-1:0] xfer_q;
   logic [LEN_W-1:0] head_len;
   logic [CNT_W-1:0] fifo_count;
   logic             push, pop;

`ifdef ARB_REQ_TIMEOUT_EN
   localparam int WAIT_W = $clog2(TIMEOUT + 1);
   logic [WAIT_W-1:0] wait_q;
   logic              abort_q, timeout_q;
`endif

   assign job_ready = (fifo_count < CNT_W'(DEPTH));
   assign push      = job_valid && job_ready;
`ifdef ARB_REQ_TIMEOUT_EN
   assign pop       = done_q || timeout_q;
`else
   assign pop       = done_q;
`endif

   job_fifo #(
      .DEPTH (DEPTH),
      .LEN_W (LEN_W),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata (job_len),
      .pop   (pop),
      .head  (head_len),
      .count (fifo_count)
   );

   // The completed job stays in the FIFO until the cycle after the done/timeout
   // pulse, so IDLE must not start while that pop is still pending.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         req_q     <= 1'b0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
         xfer_q    <= '0;
`ifdef ARB_REQ_TIMEOUT_EN
         wait_q    <= '0;
         abort_q   <= 1'b0;
         timeout_q <= 1'b0;
`endif
      end else begin
         done_q    <= 1'b0;
`ifdef ARB_REQ_TIMEOUT_EN
         timeout_q <= 1'b0;
`endif
         case (state_q)
            IDLE: begin
               req_q <= 1'b0;
               if ((fifo_count != '0) && !ack && !pop) begin
                  state_q <= REQUEST;
                  busy_q  <= 1'b1;
`ifdef ARB_REQ_TIMEOUT_EN
                  wait_q  <= '0;
`endif
               end
            end
            REQUEST: begin
               req_q <= 1'b1;
               if (ack) begin
                  state_q <= XFER;
                  xfer_q  <= head_len;
               end
`ifdef ARB_REQ_TIMEOUT_EN
               else if (wait_q == WAIT_W'(TIMEOUT)) begin
                  state_q <= RELEASE;
                  req_q   <= 1'b0;
                  abort_q <= 1'b1;
               end else begin
                  wait_q  <= wait_q + WAIT_W'(1);
               end
`endif
            end
            XFER: begin
               // A dropped ack here is a controller error; the window still runs out.
               if (xfer_q == '0) begin
                  state_q <= RELEASE;
                  req_q   <= 1'b0;
               end else begin
                  req_q   <= 1'b1;
                  xfer_q  <= xfer_q - LEN_W'(1);
               end
            end
            RELEASE: begin
               req_q <= 1'b0;
               if (!ack) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
`ifdef ARB_REQ_TIMEOUT_EN
                  if (abort_q) timeout_q <= 1'b1;
                  else         done_q    <= 1'b1;
                  abort_q <= 1'b0;
`else
                  done_q  <= 1'b1;
`endif
               end
            end
            default: begin
               state_q <= IDLE;
               req_q   <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign req   = req_q;
   assign done  = done_q;
   assign busy  = busy_q;
   assign count = fifo_count;
`ifdef ARB_REQ_TIMEOUT_EN
   assign timeout = timeout_q;
`endif

endmodule

// File: tb/tb_arb_requester.sv
// Directed bench for arb_requester: queued jobs, req/ack handshake windows,
// FIFO full/wrap, stale-ack reset recovery and (with ARB_REQ_TIMEOUT_EN) abort.
module tb_arb_requester;

   localparam int DEPTH   = 4;
   localparam int LEN_W   = 4;
   localparam int TIMEOUT = 16;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             job_valid = 1'b0;
   logic [LEN_W-1:0] job_len = '0;
   logic             job_ready, req, done, busy, ack;
   logic [2:0]       count;
`ifdef ARB_REQ_TIMEOUT_EN
   logic             timeout;
`endif

   // Controller model: when ack_auto, ack follows req with one cycle of lag.
   logic ack_auto = 1'b0;
   logic ack_man  = 1'b0;
   logic ack_lag  = 1'b0;
   logic req_prev = 1'b0;
   assign ack = ack_auto ? ack_lag : ack_man;

   int total = 0;
   int bad   = 0;
   int run   = 0;
   int done_cnt = 0;
   int to_cnt   = 0;
   int exp_q[$];
   int win_q[$];

   arb_requester #(
      .DEPTH   (DEPTH),
      .LEN_W   (LEN_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .job_valid (job_valid),
      .job_len   (job_len),
      .job_ready (job_ready),
      .req       (req),
      .ack       (ack),
      .done      (done),
      .busy      (busy),
      .count     (count)
`ifdef ARB_REQ_TIMEOUT_EN
      ,
      .timeout   (timeout)
`endif
   );

   always #5 clk = ~clk;

   // Controller model and monitor: req-high run lengths go to win_q.
   always @(negedge clk) begin
      ack_lag  = req_prev;
      req_prev = req;
      if (req === 1'b1) run++;
      else if (run != 0) begin
         win_q.push_back(run);
         run = 0;
      end
      if (done === 1'b1) done_cnt++;
`ifdef ARB_REQ_TIMEOUT_EN
      if (timeout === 1'b1) to_cnt++;
`endif
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Offer one job for one cycle; expected req-high window is len+3 with the lagging ack.
   task automatic push_job(input int len, input bit track, output int acc);
      job_len   = LEN_W'(len);
      job_valid = 1'b1;
      acc       = (job_ready === 1'b1) ? 1 : 0;
      if (acc == 1 && track) exp_q.push_back(len + 3);
      @(negedge clk);
      job_valid = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int lim);
      int n;
      n = 0;
      while (done !== 1'b1 && n < lim) begin
         @(negedge clk);
         n++;
      end
      chk(tag, done, 1);
   endtask

   task automatic check_windows(input string tag);
      int e;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (win_q.size() == 0) chk(tag, 32'hFFFF_FFFF, e);
         else                   chk(tag, win_q.pop_front(), e);
      end
      win_q.delete();
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int acc;
      int n;
      int seen;
      int base;
      int lens[6];
      lens = '{0, 1, 2, 3, 0, 1};

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_req", req, 0);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_count", count, 0);
      chk("rst_ready", job_ready, 1);
      rst = 1'b0;
      @(negedge clk);
      win_q.delete();

      // Single job, len=2: req high 5 cycles, rising 2 cycles after the push edge
      ack_auto = 1'b1;
      push_job(2, 1, acc);
      chk("single_count1", count, 1);
      chk("single_req_e0", req, 0);
      @(negedge clk);
      chk("single_req_e1", req, 0);
      chk("single_busy", busy, 1);
      @(negedge clk);
      chk("single_req_e2", req, 1);
      wait_done("single_done", 60);
      chk("single_count_at_done", count, 1);
      @(negedge clk);
      chk("single_done_pulse", done, 0);
      chk("single_count0", count, 0);
      chk("single_idle", busy, 0);
      check_windows("single_window");

      // Back-to-back fill with ack held low, then a rejected 5th push
      ack_auto = 1'b0;
      ack_man  = 1'b0;
      for (int i = 0; i < 4; i++) begin
         push_job(i, 0, acc);
         chk("fill_accept", acc, 1);
      end
      chk("fill_count4", count, 4);
      chk("fill_ready0", job_ready, 0);
      push_job(5, 0, acc);
      chk("fill_reject", acc, 0);
      chk("fill_count_still4", count, 4);
      pulse_reset();
      chk("fill_flush_count", count, 0);
      chk("fill_flush_ready", job_ready, 1);
      @(negedge clk);
      win_q.delete();

      // FIFO wrap: six jobs with a responsive controller
      ack_auto = 1'b1;
      base = done_cnt;
      for (int i = 0; i < 6; i++) begin
         n = 0;
         while (job_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
         end
         push_job(lens[i], 1, acc);
         chk("wrap_accept", acc, 1);
      end
      n = 0;
      while (done_cnt < base + 6 && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("wrap_dones", done_cnt - base, 6);
      repeat (2) @(negedge clk);
      chk("wrap_count0", count, 0);
      check_windows("wrap_window");

      // Push on the done cycle with count=2: count holds, next job runs normally
      base = done_cnt;
      push_job(3, 1, acc);
      push_job(3, 1, acc);
      wait_done("pp_done1", 80);
      chk("pp_count_before", count, 2);
      push_job(1, 1, acc);
      chk("pp_accept", acc, 1);
      chk("pp_count_after", count, 2);
      n = 0;
      while (done_cnt < base + 3 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("pp_dones", done_cnt - base, 3);
      repeat (2) @(negedge clk);
      chk("pp_count0", count, 0);
      check_windows("pp_window");

      // Stale ack: reset during XFER with ack high; req waits for ack to drop
      push_job(7, 0, acc);
      n = 0;
      while (ack !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("stale_reach_xfer", ack, 1);
      @(negedge clk);
      ack_man  = 1'b1;
      ack_auto = 1'b0;
      pulse_reset();
      chk("stale_req_after_rst", req, 0);
      chk("stale_busy_after_rst", busy, 0);
      chk("stale_count_after_rst", count, 0);
      push_job(2, 0, acc);
      seen = 0;
      repeat (4) begin
         @(negedge clk);
         if (req === 1'b1) seen++;
      end
      chk("stale_req_blocked", seen, 0);
      chk("stale_count_held", count, 1);
      ack_man = 1'b0;
      @(negedge clk);
      chk("stale_req_edge1", req, 0);
      @(negedge clk);
      chk("stale_req_edge2", req, 1);
      ack_auto = 1'b1;
      wait_done("stale_done", 60);
      @(negedge clk);
      chk("stale_count0", count, 0);
      win_q.delete();
      exp_q.delete();

`ifdef ARB_REQ_TIMEOUT_EN
      // Timeout: ack never rises; req high TIMEOUT cycles, timeout pulse, no done
      ack_auto = 1'b0;
      ack_man  = 1'b0;
      repeat (2) @(negedge clk);
      win_q.delete();
      base = done_cnt;
      seen = to_cnt;
      push_job(1, 0, acc);
      n = 0;
      while (timeout !== 1'b1 && n < 80) begin
         @(negedge clk);
         n++;
      end
      chk("to_pulse", timeout, 1);
      chk("to_count_at_pulse", count, 1);
      @(negedge clk);
      chk("to_count0", count, 0);
      chk("to_single_pulse", to_cnt - seen, 1);
      chk("to_no_done", done_cnt - base, 0);
      if (win_q.size() == 0) chk("to_window", 32'hFFFF_FFFF, TIMEOUT);
      else                   chk("to_window", win_q.pop_front(), TIMEOUT);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
